// File: rtl/axi_fifo_pkg.sv
// Shared constants and helpers for the axi_fifo_* family of stream buffers.
package axi_fifo_pkg;

    // Legal log2 storage depth for SRL-based FIFOs (one SRLC32E deep at most).
    localparam int unsigned SizeMin  = 1;
    localparam int unsigned SizeMax  = 5;

    // Physical depth and address width of one SRLC32E primitive.
    localparam int unsigned SrlDepth = 32;
    localparam int unsigned SrlAddrW = 5;

    // Total capacity in words: SRL storage plus the registered output stage.
    function automatic int unsigned fifo_cap(input int unsigned size);
        return (32'd1 << size) + 32'd1;
    endfunction

endpackage

// File: rtl/axi_fifo_srl_mem.sv
// SRLC32E-style shift-register storage: new words enter at tap 0, older words
// move one tap up per write, and any tap can be read combinationally.
module axi_fifo_srl_mem
    import axi_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned ABITS = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [WIDTH-1:0] din,
    input  logic [ABITS-1:0] addr,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0]    srl_q [SrlDepth];
    logic [SrlAddrW-1:0] tap;

    // Upper primitive address bits are tied low when ABITS < 5.
    assign tap  = SrlAddrW'(addr);
    assign dout = srl_q[tap];

    // Shift on write; the primitive has no reset so neither does this array.
    always_ff @(posedge clk) begin
        if (we) begin
            srl_q[0] <= din;
            for (int i = 1; i < SrlDepth; i++) begin
                srl_q[i] <= srl_q[i-1];
            end
        end
    end

endmodule

// File: rtl/axi_fifo_srl.sv
// AXI4-Stream FIFO: 2**SIZE words of SRL storage plus one registered output
// stage, tlast carried as a sideband bit, with space/occupied counters.
// Optional packet mode (macro AXI_FIFO_SRL_PKT_MODE_EN) holds o_tvalid low
// until at least one complete packet is buffered.
module axi_fifo_srl
    import axi_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SIZE  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [SIZE:0]    space,
    output logic [SIZE:0]    occupied
);

    localparam int unsigned    CAP      = fifo_cap(SIZE);
    localparam logic [SIZE:0]  CapCnt   = CAP[SIZE:0];
    localparam logic [SIZE:0]  CntOne   = (SIZE+1)'(1);
    localparam logic [SIZE-1:0] PtrOne  = SIZE'(1);
    localparam int unsigned    FullAtI  = (32'd1 << SIZE) - 32'd2;
    localparam logic [SIZE-1:0] FullAt  = FullAtI[SIZE-1:0];

    logic [SIZE-1:0] a_q;
    logic            empty_q;
    logic            full_q;
    logic            int_valid_q;
    logic [WIDTH-1:0] tdata_q;
    logic            tlast_q;
    logic [SIZE:0]   occupied_q;
    logic [SIZE:0]   space_q;
    logic [WIDTH:0]  tap_data;

    logic write;
    logic pop;
    logic read;
    logic int_tready;
    logic flush;

    assign flush    = reset | clear;
    assign i_tready = ~full_q;
    assign write    = i_tvalid & i_tready;
    assign pop      = ~empty_q & int_tready;
    assign read     = o_tvalid & o_tready;
    assign o_tdata  = tdata_q;
    assign o_tlast  = tlast_q;
    assign space    = space_q;
    assign occupied = occupied_q;

    axi_fifo_srl_mem #(
        .WIDTH (WIDTH + 1),
        .ABITS (SIZE)
    ) u_mem (
        .clk  (clk),
        .we   (write),
        .din  ({i_tlast, i_tdata}),
        .addr (a_q),
        .dout (tap_data)
    );

`ifdef AXI_FIFO_SRL_PKT_MODE_EN
    logic [SIZE:0] pkt_count_q;
    logic          pkt_inc;
    logic          pkt_dec;

    assign pkt_inc  = write & i_tlast;
    assign pkt_dec  = read & o_tlast;
    assign o_tvalid = int_valid_q & (pkt_count_q != '0);

    // Count complete packets held anywhere in the FIFO.
    always_ff @(posedge clk) begin
        if (flush) begin
            pkt_count_q <= '0;
        end else if (pkt_inc && !pkt_dec) begin
            pkt_count_q <= pkt_count_q + CntOne;
        end else if (pkt_dec && !pkt_inc) begin
            pkt_count_q <= pkt_count_q - CntOne;
        end
    end
`else
    assign o_tvalid = int_valid_q;
`endif

    // A word gated off by packet mode still occupies the output register, so
    // the stage only advances when it is empty or its word is being read.
    always_comb begin
        int_tready = (o_tready & o_tvalid) | ~int_valid_q;
    end

    // Read pointer tracks the oldest word in storage; empty/full flags.
    always_ff @(posedge clk) begin
        if (flush) begin
            a_q     <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else if (write && !pop) begin
            empty_q <= 1'b0;
            if (!empty_q) begin
                a_q <= a_q + PtrOne;
                if (a_q == FullAt) begin
                    full_q <= 1'b1;
                end
            end
        end else if (pop && !write) begin
            full_q <= 1'b0;
            if (a_q == '0) begin
                empty_q <= 1'b1;
            end else begin
                a_q <= a_q - PtrOne;
            end
        end
    end

    // Output register loads the oldest stored word whenever it may advance.
    always_ff @(posedge clk) begin
        if (flush) begin
            tdata_q     <= '0;
            tlast_q     <= 1'b0;
            int_valid_q <= 1'b0;
        end else if (int_tready) begin
            tdata_q     <= tap_data[WIDTH-1:0];
            tlast_q     <= tap_data[WIDTH];
            int_valid_q <= ~empty_q;
        end
    end

    // Occupancy counters move on the interface handshakes, never the pop.
    always_ff @(posedge clk) begin
        if (flush) begin
            occupied_q <= '0;
            space_q    <= CapCnt;
        end else if (write && !read) begin
            occupied_q <= occupied_q + CntOne;
            space_q    <= space_q - CntOne;
        end else if (read && !write) begin
            occupied_q <= occupied_q - CntOne;
            space_q    <= space_q + CntOne;
        end
    end

endmodule
